// File: rtl/inst_fetch_unit.sv
// LEGv8 instruction fetch: PC register, same-cycle ROM interface, tagged prefetch FIFO, valid/ready output.
// Optional feature: define IFU_HALT_ON_ZERO_EN to stop fetching at the first all-zero instruction word.
module inst_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 4,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);
    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       word;
    } entry_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    entry_t            head;
    logic [ADDR_W-1:0] pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              fetch;
    logic              push;
    logic              zero_word;

`ifdef IFU_HALT_ON_ZERO_EN
    logic halted_q;

    assign zero_word = (rom_data == 32'h0000_0000);
    assign halted    = halted_q;

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            halted_q <= 1'b0;
        end else if (fetch && zero_word) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign zero_word = 1'b0;
    assign halted    = 1'b0;
`endif

    assign rom_addr   = pc;
    assign head       = fifo_mem[rd_ptr];
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head.word : 32'h0;
    assign inst_pc    = inst_valid ? head.pc : '0;

    // A full FIFO may still fetch when the head leaves in the same cycle.
    always_comb begin
        pop   = inst_valid & inst_ready;
        fetch = ~redirect_valid & ~halted & ((count < DEPTH_C) | pop);
        push  = fetch & ~zero_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + STEP_C;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only observable once count covers them, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: pc, word: rom_data};
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, backpressure, redirects, PC wrap, halt-on-zero, reset.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] seq_word [0:5] = '{32'h913E8021, 32'h913E8042, 32'hD3602821,
                                    32'hD3602842, 32'hD2800281, 32'hF2800282};

    inst_fetch_unit #(
        .ADDR_W(32), .RESET_PC(32'd0), .PC_STEP(4), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'd0:         return 32'h913E8021;
            32'd4:         return 32'h913E8042;
            32'd8:         return 32'hD3602821;
            32'd12:        return 32'hD3602842;
            32'd16:        return 32'hD2800281;
            32'd20:        return 32'hF2800282;
            32'hFFFFFFFC:  return 32'hD503201F;
            default:       return 32'h00000000;
        endcase
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        tick(); tick();
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b inst=%h pc=%h expected 0/0/0", inst_valid, inst, inst_pc);
        end
        checks++;
        if (rom_addr !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr: rom_addr=%h halted=%b expected 0/0", rom_addr, halted);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== seq_word[i]) begin
                errors++;
                $display("FAIL seq_head[%0d]: valid=%b pc=%h inst=%h expected 1/%h/%h",
                         i, inst_valid, inst_pc, inst, 32'(4 * i), seq_word[i]);
            end
        end
        tick();
`ifdef IFU_HALT_ON_ZERO_EN
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (inst_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 32'd24) begin
                errors++;
                $display("FAIL halt_state[%0d]: valid=%b halted=%b rom_addr=%h expected 0/1/18",
                         i, inst_valid, halted, rom_addr);
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 32'd0) begin
            errors++;
            $display("FAIL halt_clear: halted=%b valid=%b rom_addr=%h expected 0/0/0", halted, inst_valid, rom_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== 32'h913E8021) begin
            errors++;
            $display("FAIL halt_resume: valid=%b pc=%h inst=%h expected 1/0/913e8021", inst_valid, inst_pc, inst);
        end
`else
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd24 || inst !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL zero_word: valid=%b pc=%h inst=%h halted=%b expected 1/18/0/0",
                     inst_valid, inst_pc, inst, halted);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr [0:3] = '{32'd4, 32'd8, 32'd8, 32'd8};
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rom_addr !== exp_addr[i] || inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== 32'h913E8021) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rom_addr=%h valid=%b pc=%h inst=%h expected %h/1/0/913e8021",
                         i, rom_addr, inst_valid, inst_pc, inst, exp_addr[i]);
            end
        end
        inst_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== seq_word[i] || rom_addr !== 32'(4 * i + 8)) begin
                errors++;
                $display("FAIL bp_release[%0d]: valid=%b pc=%h inst=%h rom_addr=%h expected 1/%h/%h/%h",
                         i, inst_valid, inst_pc, inst, rom_addr, 32'(4 * i), seq_word[i], 32'(4 * i + 8));
            end
        end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        tick();
        checks++;
        if (inst_pc !== 32'd12 || rom_addr !== 32'd20) begin
            errors++;
            $display("FAIL redir_pre_full: pc=%h rom_addr=%h expected c/14", inst_pc, rom_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd17;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'd16 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL redir_flush: valid=%b rom_addr=%h inst=%h pc=%h expected 0/10/0/0",
                     inst_valid, rom_addr, inst, inst_pc);
        end
        for (int i = 4; i < 6; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== seq_word[i]) begin
                errors++;
                $display("FAIL redir_target[%0d]: valid=%b pc=%h inst=%h expected 1/%h/%h",
                         i, inst_valid, inst_pc, inst, 32'(4 * i), seq_word[i]);
            end
        end
    endtask

    task automatic test_redirect_pop();
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL rpop_pre: valid=%b expected 1", inst_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd0; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'd0) begin
            errors++;
            $display("FAIL rpop_empty: valid=%b rom_addr=%h expected 0/0", inst_valid, rom_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== seq_word[i]) begin
                errors++;
                $display("FAIL rpop_stream[%0d]: valid=%b pc=%h inst=%h expected 1/%h/%h",
                         i, inst_valid, inst_pc, inst, 32'(4 * i), seq_word[i]);
            end
        end
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (rom_addr !== 32'hFFFFFFFC || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_target: rom_addr=%h valid=%b expected fffffffc/0", rom_addr, inst_valid);
        end
        tick();
        checks++;
        if (inst_pc !== 32'hFFFFFFFC || inst !== 32'hD503201F || rom_addr !== 32'd0) begin
            errors++;
            $display("FAIL wrap_last: pc=%h inst=%h rom_addr=%h expected fffffffc/d503201f/0", inst_pc, inst, rom_addr);
        end
        tick();
        checks++;
        if (inst_pc !== 32'd0 || inst !== 32'h913E8021 || rom_addr !== 32'd4) begin
            errors++;
            $display("FAIL wrap_first: pc=%h inst=%h rom_addr=%h expected 0/913e8021/4", inst_pc, inst, rom_addr);
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        tick();
        checks++;
        if (rom_addr !== 32'd8 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: rom_addr=%h valid=%b expected 8/0", rom_addr, inst_valid);
        end
        redirect_pc = 32'd16;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (rom_addr !== 32'd16 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: rom_addr=%h valid=%b expected 10/0", rom_addr, inst_valid);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd16 || inst !== 32'hD2800281) begin
            errors++;
            $display("FAIL b2b_head: valid=%b pc=%h inst=%h expected 1/10/d2800281", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd12; inst_ready = 1'b1;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'd0 || inst !== 32'h0 || inst_pc !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b rom_addr=%h inst=%h pc=%h halted=%b expected all 0",
                     inst_valid, rom_addr, inst, inst_pc, halted);
        end
        reset = 1'b0; redirect_valid = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== 32'h913E8021) begin
            errors++;
            $display("FAIL mid_reset_resume: valid=%b pc=%h inst=%h expected 1/0/913e8021", inst_valid, inst_pc, inst);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_pc_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
